// File: rtl/sdram_page_streamer.sv
// sdram_page_streamer: ping-pong 256-word page buffers filled by the SDRAM page-DMA port, streamed out on valid/ready.
// Optional build macro SDRAM_PAGE_STREAMER_UNDERRUN_CNT_EN adds the underrun_cnt output.
module sdram_page_streamer #(
  parameter logic [15:0] PAGE_COUNT = 16'd1200,
  parameter int PAGE_WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] base_page,
  output logic        busy,
  output logic        done,
  output logic        buffDMAread_req,
  input  logic        buffDMAread_ack,
  output logic [15:0] buffDMAread_addr,
  output logic        buffDMAread_A_B,
  input  logic [15:0] buffDMAread_wrdata,
  input  logic [7:0]  buffDMAread_wraddress,
  input  logic        buffDMAreadA_wren,
  input  logic        buffDMAreadB_wren,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef SDRAM_PAGE_STREAMER_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int DEPTH = 1 << PAGE_WORDS_LOG2;
  localparam logic [23:0] TOTAL = {PAGE_COUNT, 8'h00};

  typedef enum logic [1:0] {
    F_IDLE, F_CHECK, F_REQ, F_RELEASE
  } fill_t;

  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];

  fill_t       fstate, fnext;
  logic [15:0] next_page;
  logic [15:0] pages_left;
  logic        target;
  logic        full_a, full_b;
  logic        start_ok, tgt_full, page_done;

  logic        rd_buf;
  logic [7:0]  rd_ptr;
  logic        rd_pend, rd_issue, cur_full;
  logic [15:0] rd_word;
  logic [15:0] f0, f1;
  logic [1:0]  fifo_cnt, inflight;
  logic        load, pop, push;
  logic        accept, last;
  logic [23:0] words_left;

  assign start_ok = start && !busy;
  assign tgt_full = target ? full_a : full_b;
  assign buffDMAread_addr = next_page;
  assign buffDMAread_A_B = target;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fstate <= F_IDLE;
    else          fstate <= fnext;
  end

  // A fresh request waits for ack to be low so the four-phase cycle never overlaps.
  always_comb begin
    fnext = fstate;
    unique case (fstate)
      F_IDLE:    if (start_ok) fnext = F_CHECK;
      F_CHECK: begin
        if (pages_left == 16'd0)                fnext = F_IDLE;
        else if (!tgt_full && !buffDMAread_ack) fnext = F_REQ;
      end
      F_REQ:     if (buffDMAread_ack)  fnext = F_RELEASE;
      F_RELEASE: if (!buffDMAread_ack) fnext = F_CHECK;
      default:   fnext = F_IDLE;
    endcase
  end

  always_comb begin
    buffDMAread_req = (fstate == F_REQ);
    page_done = (fstate == F_RELEASE) && !buffDMAread_ack;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_page  <= 16'd0;
      pages_left <= 16'd0;
      target     <= 1'b0;
    end else if (start_ok) begin
      next_page  <= base_page;
      pages_left <= PAGE_COUNT;
      target     <= 1'b1;
    end else if (page_done) begin
      next_page  <= next_page + 16'd1;
      pages_left <= pages_left - 16'd1;
      target     <= ~target;
    end
  end

  assign cur_full = rd_buf ? full_a : full_b;
  assign inflight = fifo_cnt + {1'b0, rd_pend};
  assign rd_issue = cur_full && (inflight < 2'd2);

  always_ff @(posedge clk) begin
    if (buffDMAreadA_wren) mem_a[buffDMAread_wraddress] <= buffDMAread_wrdata;
    if (buffDMAreadB_wren) mem_b[buffDMAread_wraddress] <= buffDMAread_wrdata;
    if (rd_issue) rd_word <= rd_buf ? mem_a[rd_ptr] : mem_b[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
      rd_buf <= 1'b1;
      rd_ptr <= 8'd0;
    end else begin
      if (page_done && target)                   full_a <= 1'b1;
      else if (rd_issue && rd_buf && &rd_ptr)    full_a <= 1'b0;
      if (page_done && !target)                  full_b <= 1'b1;
      else if (rd_issue && !rd_buf && &rd_ptr)   full_b <= 1'b0;
      if (start_ok) begin
        rd_buf <= 1'b1;
        rd_ptr <= 8'd0;
      end else if (rd_issue) begin
        rd_ptr <= rd_ptr + 8'd1;
        if (&rd_ptr) rd_buf <= ~rd_buf;
      end
    end
  end

  // RAM output bypasses the prefetch when the output register is free.
  assign load = (!out_valid || out_ready) && (fifo_cnt != 2'd0 || rd_pend);
  assign pop  = load && (fifo_cnt != 2'd0);
  assign push = rd_pend && !(load && fifo_cnt == 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend   <= 1'b0;
      f0        <= 16'd0;
      f1        <= 16'd0;
      fifo_cnt  <= 2'd0;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      if (load) begin
        out_data  <= pop ? f0 : rd_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pop && push) begin
        if (fifo_cnt == 2'd1) f0 <= rd_word;
        else begin
          f0 <= f1;
          f1 <= rd_word;
        end
      end else if (pop) begin
        f0       <= f1;
        fifo_cnt <= fifo_cnt - 2'd1;
      end else if (push) begin
        if (fifo_cnt == 2'd0) f0 <= rd_word;
        else                  f1 <= rd_word;
        fifo_cnt <= fifo_cnt + 2'd1;
      end
    end
  end

  assign accept = out_valid && out_ready;
  assign last   = accept && (words_left == 24'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      words_left <= 24'd0;
    end else if (start_ok) begin
      busy       <= 1'b1;
      done       <= 1'b0;
      words_left <= TOTAL;
    end else begin
      done <= last;
      if (done) busy <= 1'b0;
      if (accept && words_left != 24'd0) words_left <= words_left - 24'd1;
    end
  end

`ifdef SDRAM_PAGE_STREAMER_UNDERRUN_CNT_EN
  logic first_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_seen   <= 1'b0;
      underrun_cnt <= 16'd0;
    end else if (start_ok) begin
      first_seen   <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      if (out_valid) first_seen <= 1'b1;
      if (busy && out_ready && !out_valid && first_seen &&
          words_left != 24'd0 && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sdram_page_streamer.md
Name: sdram_page_streamer

Overview:
- Downstream consumer of the SDRAM bus page-DMA port. Owns the two 256x16 ping-pong page buffers (A/B) that the DMA port fills.
- Issues page-read requests over the req/ack four-phase handshake and streams the buffered words to a sink (e.g. video scanout) over a valid/ready interface.
- Runs entirely on the DMA write clock, so no clock crossing exists between the DMA port and this block.

Parameters:
- PAGE_COUNT, 16'd1200: pages per frame (1..65535); each page is 256 words.
- PAGE_WORDS_LOG2, 8: fixed at 8. Buffer depth is 256; other values are unsupported.

Ports:
- clk  input  1  DMA clock (driven from buffDMAread_clk)
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: begin a frame at base_page; ignored while busy=1
- base_page  input  16  first page address; sampled on an accepted start
- busy  output  1  high from an accepted start until done
- done  output  1  one-cycle pulse after the last word of the frame is accepted
- buffDMAread_req  output  1  page-read request
- buffDMAread_ack  input  1  page-read acknowledge
- buffDMAread_addr  output  16  page address; stable while req=1
- buffDMAread_A_B  output  1  1 = target buffer A, 0 = target buffer B; stable while req=1
- buffDMAread_wrdata  input  16  buffer write data
- buffDMAread_wraddress  input  8  buffer write address
- buffDMAreadA_wren  input  1  write enable, buffer A
- buffDMAreadB_wren  input  1  write enable, buffer B
- out_data  output  16  stream data
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready

Behaviour:
- Reset values: all outputs 0. Both buffer-full flags cleared. Both FSMs in IDLE. Reset mid-transfer drops req immediately; buffer RAM contents are not cleared.
- Buffer writes: on a cycle with A_wren (B_wren), wrdata is written to A[wraddress] (B[wraddress]). Writes are accepted in every state. A and B enables asserted together write both buffers.
- Fill FSM, IDLE:
  - On accepted start: latch next_page=base_page, target=A, pages_left=PAGE_COUNT, go to CHECK.
- Fill FSM, CHECK:
  - If pages_left==0, go to IDLE.
  - Else if the target buffer is not full, go to REQ.
  - Else stay in CHECK.
- Fill FSM, REQ:
  - req=1, addr=next_page, A_B=(target==A).
  - When ack==1: req=0, go to RELEASE.
- Fill FSM, RELEASE:
  - Wait for ack==0, then set the target full flag, next_page+=1 (mod 2^16 wrap), pages_left-=1, toggle target, go to CHECK.
- Handshake rule: a new req is never raised while ack==1.
- Read FSM:
  - Starts on buffer A, read pointer 0.
  - While the current buffer is full, reads RAM sequentially. RAM read latency is 1 cycle; the output register is fed through a 2-entry prefetch.
  - First out_valid comes exactly 2 cycles after buffer A's full flag sets.
  - Sustains 1 word/cycle with out_ready held high, including across the A/B boundary when the next buffer is already full.
- Stream rule: out_data is held stable while out_valid=1 and out_ready=0.
- Buffer release: when word 255 of a buffer is handed to the prefetch, that buffer's full flag clears and the read buffer toggles.
- Same-cycle set and clear: if the fill FSM sets a flag in the same cycle the read FSM clears the other flag, both actions take effect.
- End of frame: after the word PAGE_COUNT*256-1 is accepted (valid&&ready), done=1 for one cycle, then busy=0.
- Underrun: when the read buffer is empty, out_valid=0. No data is repeated or dropped.

Optional Feature:
- Macro: SDRAM_PAGE_STREAMER_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt[15:0], a saturating count of cycles with busy=1, out_ready=1 and out_valid=0, excluding cycles before the first word of the frame.
  - The count clears on an accepted start and on reset.
- When undefined:
  - The port and the counter are absent.
  - Behaviour is otherwise identical.

Test Plan:
- PAGE_COUNT=2, base_page=16'h0010, DMA model acks after 5 cycles and writes A[i]=i then B[i]=16'h100+i; out_ready=1 -> reqs with addr 0x0010/A_B=1 then 0x0011/A_B=0; 512 contiguous words 0x0000..0x00FF, 0x0100..0x01FF; done pulses once; busy falls.
- base_page=16'hFFFF, PAGE_COUNT=2 -> second request addr 16'h0000 (wrap).
- out_ready toggles 1/0 each cycle -> out_data stable while stalled; all 512 words received in order, none duplicated.
- DMA model stalls ack 400 cycles for page 2 -> out_valid low after word 255 until B is filled; then resumes with 0x0100. With the macro defined, underrun_cnt equals the measured gap cycles.
- start pulsed again while busy -> ignored; no extra req; frame unaffected.
- reset_n low while req=1 -> req, out_valid, busy low asynchronously; after release, a new start runs a clean frame from buffer A.
